oam_dma_controller: RTL and testbench

Sprite DMA engine for the $4014 register. It sits directly upstream of the memory manager on the CPU-side bus, between the CPU core and the memory manager's cpu_addr/cpu_rnw/cpu_data_in inputs. On a CPU write to $4014 it halts the CPU, then copies 256 bytes from page $XX00–$XXFF to the PPU OAM data port ($2004) through the memory manager. When idle it passes the CPU bus straight through.

---
 rtl/oam_dma_controller.sv | 165 ++++++++++++++++
 tb/tb_oam_dma_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// ---------------------------------------------------------------------------
// oam_dma_controller
//
// Sprite DMA engine for the $4014 register. It sits between the CPU core and
// the memory manager. A CPU write to DMA_REG_ADDR freezes the CPU and copies
// the 256-byte page {page,00}..{page,FF} to OAM_DATA_ADDR, one read cycle and
// one write cycle per byte. While idle the CPU bus is passed straight through.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active low
//   ph2_rising    one-clk strobe at the start of each CPU cycle
//   ph2_falling   one-clk strobe at the end of the PH2-high phase
//   cpu_addr_in   CPU core address
//   cpu_rnw_in    CPU core read/not-write
//   cpu_wdata_in  CPU core write data
//   bus_addr      address to the memory manager
//   bus_rnw       read/not-write to the memory manager
//   bus_wdata     write data to the memory manager
//   bus_rdata     read data from the memory manager (valid at ph2_falling)
//   cpu_rdy       0 freezes the CPU core
//   dma_active    1 while the DMA owns the bus
// ---------------------------------------------------------------------------
module oam_dma_controller #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph2_rising,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_addr_in,
    input  logic        cpu_rnw_in,
    input  logic [7:0]  cpu_wdata_in,
    output logic [15:0] bus_addr,
    output logic        bus_rnw,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        cpu_rdy,
    output logic        dma_active
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_e;

    state_e      state_q, state_d;
    logic        cyc_odd_q, cyc_odd_d;
    logic        pending_q, pending_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        rdy_q, rdy_d;
    logic        act_q, act_d;
    logic        trigger;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cyc_odd_q <= 1'b0;
            pending_q <= 1'b0;
            page_q    <= 8'h00;
            idx_q     <= 8'h00;
            data_q    <= 8'h00;
            rdy_q     <= 1'b1;
            act_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_odd_q <= cyc_odd_d;
            pending_q <= pending_d;
            page_q    <= page_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            act_q     <= act_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cyc_odd_d = cyc_odd_q;
        pending_d = pending_q;
        page_d    = page_q;
        idx_d     = idx_q;
        data_d    = data_q;
        bus_addr  = cpu_addr_in;
        bus_rnw   = cpu_rnw_in;
        bus_wdata = cpu_wdata_in;

        if (ph2_rising) begin
            cyc_odd_d = ~cyc_odd_q;
        end

        // The CPU write commits at ph2_falling, so that is where it is caught.
        trigger = (state_q == S_IDLE) && ph2_falling && !cpu_rnw_in &&
                  (cpu_addr_in == DMA_REG_ADDR);

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d    = cpu_wdata_in;
                    pending_d = 1'b1;
                    idx_d     = 8'h00;
                end
                if (ph2_rising && pending_q) begin
                    state_d   = S_HALT;
                    pending_d = 1'b0;
                end
            end
            S_HALT: begin
                bus_rnw = 1'b1;
                // cyc_odd_q still holds the parity of the cycle now ending;
                // the cycle about to start is even when that one was odd.
                if (ph2_rising) begin
                    state_d = cyc_odd_q ? S_READ : S_ALIGN;
                end
            end
            S_ALIGN: begin
                bus_rnw = 1'b1;
                if (ph2_rising) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                bus_addr  = {page_q, idx_q};
                bus_rnw   = 1'b1;
                bus_wdata = data_q;
                if (ph2_falling) begin
                    data_d = bus_rdata;
                end
                if (ph2_rising) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_addr  = OAM_DATA_ADDR;
                bus_rnw   = 1'b0;
                bus_wdata = data_q;
                if (ph2_falling) begin
                    idx_d = idx_q + 8'd1;
                end
                // idx has already advanced at ph2_falling; a wrap to 0 means
                // byte 255 was the one just written.
                if (ph2_rising) begin
                    state_d = (idx_q == 8'h00) ? S_IDLE : S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // state only moves on ph2_rising, so these registers follow it there.
        rdy_d = (state_d == S_IDLE);
        act_d = (state_d != S_IDLE);
    end

    assign cpu_rdy    = rdy_q;
    assign dma_active = act_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
module tb_oam_dma_controller;

    localparam logic [15:0] DMA_A  = 16'h4014;
    localparam logic [15:0] OAM_A  = 16'h2004;
    localparam logic [15:0] IDLE_A = 16'hFFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        ph2_rising, ph2_falling;
    logic [15:0] cpu_addr_in;
    logic        cpu_rnw_in;
    logic [7:0]  cpu_wdata_in;
    logic [15:0] bus_addr;
    logic        bus_rnw;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        cpu_rdy, dma_active;

    logic [1:0]  ph = 2'd0;
    logic [7:0]  mem [0:65535];
    int          nrise;
    int          total = 0;
    int          bad = 0;
    int          halted = 0;
    int          dummies = 0;
    int          nwrites = 0;
    logic [7:0]  last_w = 8'h00;
    logic [7:0]  exp_w[$];
    logic [15:0] exp_r[$];

    oam_dma_controller #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ph2_rising  (ph2_rising),
        .ph2_falling (ph2_falling),
        .cpu_addr_in (cpu_addr_in),
        .cpu_rnw_in  (cpu_rnw_in),
        .cpu_wdata_in(cpu_wdata_in),
        .bus_addr    (bus_addr),
        .bus_rnw     (bus_rnw),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .cpu_rdy     (cpu_rdy),
        .dma_active  (dma_active)
    );

    always #5 clk = ~clk;

    // Four clks per CPU cycle: rising strobe in phase 0, falling in phase 2.
    always @(posedge clk) ph <= ph + 2'd1;
    assign ph2_rising  = (ph == 2'd0);
    assign ph2_falling = (ph == 2'd2);

    always @(posedge clk or negedge rst) begin
        if (!rst) nrise <= 0;
        else if (ph == 2'd0) nrise <= nrise + 1;
    end

    assign bus_rdata = mem[bus_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Memory side: sampled on the negedge just before the ph2_falling edge.
    always @(negedge clk) begin
        if (rst && ph == 2'd2) begin
            if (!bus_rnw && bus_addr == OAM_A) begin
                nwrites++;
                last_w = bus_wdata;
                if (exp_w.size() == 0) begin
                    check("oam_write_unexpected", {16'h0, bus_addr}, 32'hFFFF);
                end else begin
                    check("oam_write_data", bus_wdata, exp_w.pop_front());
                end
            end else if (!bus_rnw) begin
                mem[bus_addr] = bus_wdata;
            end else if (dma_active) begin
                if (bus_addr == IDLE_A) begin
                    dummies++;
                end else if (exp_r.size() == 0) begin
                    check("dma_read_unexpected", bus_addr, 32'hFFFF);
                end else begin
                    check("dma_read_addr", bus_addr, exp_r.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst && ph == 2'd1 && !cpu_rdy) halted++;
    end

    task automatic cpu_cycle(input logic [15:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        while (ph != 2'd0) @(negedge clk);
        cpu_addr_in  = a;
        cpu_rnw_in   = r;
        cpu_wdata_in = d;
        @(posedge clk);
    endtask

    task automatic start_dma(input logic [7:0] pg, input int odd);
        @(negedge clk);
        while (!(ph == 2'd0 && ((nrise + 1) % 2) == odd)) @(negedge clk);
        cpu_addr_in  = DMA_A;
        cpu_rnw_in   = 1'b0;
        cpu_wdata_in = pg;
        for (int i = 0; i < 256; i++) begin
            exp_r.push_back({pg, 8'(i)});
            exp_w.push_back(mem[{pg, 8'(i)}]);
        end
        @(posedge clk);
        cpu_cycle(IDLE_A, 1'b1, 8'h00);
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (!dma_active && cpu_rdy && exp_w.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check(name, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_writes(input int base, input int cnt);
        bit ok = 0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (nwrites - base >= cnt) begin
                ok = 1;
                break;
            end
        end
        check("wait_writes", {31'h0, ok}, 32'h1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic        r;
        logic [7:0]  d;
        logic [15:0] ea;
        logic        er;
        logic [7:0]  ed;
    } vec_t;

    vec_t vt[5];
    int   base;

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7) ^ 8'(a >> 8);
        for (int i = 0; i < 256; i++) begin
            mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
            mem[16'h8000 + i] = 8'hC3 - 8'(i * 5);
        end

        vt[0] = '{16'h0005, 1'b1, 8'h00, 16'h0005, 1'b1, 8'h00};
        vt[1] = '{16'h4015, 1'b0, 8'h33, 16'h4015, 1'b0, 8'h33};
        vt[2] = '{16'h4014, 1'b1, 8'h02, 16'h4014, 1'b1, 8'h02};
        vt[3] = '{16'h0300, 1'b0, 8'hA5, 16'h0300, 1'b0, 8'hA5};
        vt[4] = '{16'hFFFC, 1'b1, 8'h7E, 16'hFFFC, 1'b1, 8'h7E};

        rst          = 1'b0;
        cpu_addr_in  = 16'h1234;
        cpu_rnw_in   = 1'b1;
        cpu_wdata_in = 8'h00;
        repeat (6) @(negedge clk);
        check("reset_rdy", {31'h0, cpu_rdy}, 32'h1);
        check("reset_active", {31'h0, dma_active}, 32'h0);
        check("reset_bus_addr", bus_addr, 32'h1234);
        check("reset_bus_rnw", {31'h0, bus_rnw}, 32'h1);
        rst = 1'b1;

        // Pass-through while idle.
        halted = 0;
        for (int k = 0; k < 5; k++) begin
            cpu_cycle(vt[k].a, vt[k].r, vt[k].d);
            @(negedge clk);
            while (ph != 2'd2) @(negedge clk);
            check("idle_addr", bus_addr, vt[k].ea);
            check("idle_rnw", {31'h0, bus_rnw}, {31'h0, vt[k].er});
            check("idle_wdata", bus_wdata, vt[k].ed);
            check("idle_rdy", {31'h0, cpu_rdy}, 32'h1);
        end
        cpu_cycle(IDLE_A, 1'b1, 8'h00);
        repeat (12) @(negedge clk);
        check("idle_no_halt", halted, 0);
        check("idle_no_active", {31'h0, dma_active}, 32'h0);

        // Even-cycle trigger.
        halted = 0; dummies = 0;
        start_dma(8'h02, 0);
        wait_done("even_done");
        check("even_halted", halted, 513);
        check("even_dummies", dummies, 1);
        check("even_reads_left", exp_r.size(), 0);

        // Odd-cycle trigger: one extra alignment cycle.
        halted = 0; dummies = 0;
        start_dma(8'h02, 1);
        wait_done("odd_done");
        check("odd_halted", halted, 514);
        check("odd_dummies", dummies, 2);
        check("odd_reads_left", exp_r.size(), 0);

        // ROM page.
        halted = 0; dummies = 0;
        start_dma(8'h80, 0);
        wait_done("rom_done");
        check("rom_halted", halted, 513);
        check("rom_last_byte", last_w, mem[16'h80FF]);
        repeat (4) @(negedge clk);
        check("rom_after_rdy", {31'h0, cpu_rdy}, 32'h1);
        check("rom_after_active", {31'h0, dma_active}, 32'h0);

        // Reset during the 100th write.
        base = nwrites;
        start_dma(8'h02, 0);
        wait_writes(base, 100);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rdy", {31'h0, cpu_rdy}, 32'h1);
        check("abort_active", {31'h0, dma_active}, 32'h0);
        check("abort_bus_addr", bus_addr, IDLE_A);
        check("abort_bus_rnw", {31'h0, bus_rnw}, 32'h1);
        exp_w.delete();
        exp_r.delete();
        base = nwrites;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_writes", nwrites - base, 0);
        halted = 0; dummies = 0;
        start_dma(8'h02, 1);
        wait_done("restart_done");
        check("restart_halted", halted, 514);
        check("restart_reads_left", exp_r.size(), 0);

        // A second $4014 write during the transfer is ignored.
        halted = 0; dummies = 0;
        base = nwrites;
        start_dma(8'h02, 0);
        wait_writes(base, 50);
        cpu_cycle(DMA_A, 1'b0, 8'h80);
        cpu_cycle(IDLE_A, 1'b1, 8'h00);
        wait_done("retrig_done");
        repeat (40) @(negedge clk);
        check("retrig_halted", halted, 513);
        check("retrig_writes", nwrites - base, 256);
        check("retrig_rdy", {31'h0, cpu_rdy}, 32'h1);
        check("retrig_reads_left", exp_r.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
